// File: rtl/axi_lib_pkg.sv
// rtl/axi_lib_pkg.sv - shared AXI constants, response ranking and splitter state type
package axi_lib_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } axi_splitter_state_t;

    // EXOKAY folds to OKAY, so the numeric maximum of the folded codes is the worst.
    function automatic logic [1:0] axi_resp_worst(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] ra;
        logic [1:0] rb;
        ra = (a == AXI_RESP_EXOKAY) ? AXI_RESP_OKAY : a;
        rb = (b == AXI_RESP_EXOKAY) ? AXI_RESP_OKAY : b;
        return (ra > rb) ? ra : rb;
    endfunction

endpackage

// File: rtl/sync_fifo_len.sv
// rtl/sync_fifo_len.sv - small synchronous FIFO carrying per-burst beat counts
module sync_fifo_len #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             m_tready,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign pop      = m_tvalid && m_tready;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push     = s_tvalid && (!full || m_tready);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/axi4_master_burst_splitter.sv
// rtl/axi4_master_burst_splitter.sv - splits one user command into 4 KiB-safe INCR bursts
module axi4_master_burst_splitter
    import axi_lib_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH               = 32,
    parameter int AXI_DATA_WIDTH               = 32,
    parameter int AXI_ID_WIDTH                 = 1,
    parameter int MAX_BURST_LEN                = 16,
    parameter int MAX_OUTSTANDING              = 4,
    parameter int MAX_TOTAL_TRANSACTION_LENGTH = 4096
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             i_cmd_valid,
    output logic                                             o_cmd_ready,
    input  logic                                             i_cmd_direction,
    input  logic [AXI_ADDR_WIDTH-1:0]                        i_cmd_addr,
    input  logic [$clog2(MAX_TOTAL_TRANSACTION_LENGTH+1)-1:0] i_cmd_num_words,
    input  logic [AXI_ID_WIDTH-1:0]                          i_cmd_id,
    output logic [AXI_ADDR_WIDTH-1:0]                        o_ax_addr,
    output logic [7:0]                                       o_ax_len,
    output logic [AXI_ID_WIDTH-1:0]                          o_ax_id,
    output logic [2:0]                                       o_ax_size,
    output logic [1:0]                                       o_ax_burst,
    output logic                                             o_awvalid,
    input  logic                                             i_awready,
    output logic                                             o_arvalid,
    input  logic                                             i_arready,
    input  logic                                             i_bvalid,
    input  logic [1:0]                                       i_bresp,
    output logic                                             o_bready,
    input  logic                                             i_rlast_hs,
    input  logic [1:0]                                       i_rresp_last,
    output logic [8:0]                                       o_wburst_len,
    output logic                                             o_wburst_valid,
    input  logic                                             i_wburst_ready,
    output logic                                             o_busy,
    output logic                                             o_done,
    output logic [1:0]                                       o_resp,
    output logic                                             o_protocol_err,
    input  logic                                             i_clear_messages
);

    localparam int SIZE = $clog2(AXI_DATA_WIDTH / 8);
    localparam int NW   = $clog2(MAX_TOTAL_TRANSACTION_LENGTH + 1);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW   = (NW > 13) ? NW : 13;

    axi_splitter_state_t       state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [NW-1:0]             remaining_q;
    logic                      dir_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      ax_valid_q;
    logic [8:0]                len_q;
    logic [OW-1:0]             cnt_q, cnt_d;
    logic                      done_q;
    logic [1:0]                resp_d;
    logic                      perr_d;
    logic                      q_full;
    logic                      cmd_accept, ax_hs, comp_ok, stray, slot_free, issue_ok, last_burst;
    logic [12:0]               beats_to_4k;
    logic [CW-1:0]             len_c;
    logic [1:0]                comp_resp;

    assign o_cmd_ready = (state_q == S_IDLE) && rst_n;
    assign cmd_accept  = i_cmd_valid && o_cmd_ready;
    assign o_awvalid   = ax_valid_q && !dir_q;
    assign o_arvalid   = ax_valid_q && dir_q;
    assign ax_hs       = (o_awvalid && i_awready) || (o_arvalid && i_arready);
    assign o_bready    = (cnt_q != '0) && !dir_q;
    assign comp_ok     = (cnt_q != '0) && (dir_q ? i_rlast_hs : i_bvalid);
    assign stray       = (cnt_q == '0) && (i_bvalid || i_rlast_hs);
    assign comp_resp   = dir_q ? i_rresp_last : i_bresp;
    // A completion in this cycle frees a slot, so the next burst can be registered now.
    assign slot_free   = (cnt_q < OW'(MAX_OUTSTANDING)) || comp_ok;
    assign issue_ok    = (state_q == S_ISSUE) && !ax_valid_q && slot_free && (dir_q || !q_full);
    assign last_burst  = (remaining_q == NW'(len_q));
    assign beats_to_4k = (13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE;
    assign o_ax_id     = id_q;
    assign o_ax_size   = 3'(SIZE);
    assign o_ax_burst  = AXI_BURST_INCR;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;

    always_comb begin
        len_c = CW'(remaining_q);
        if (len_c > CW'(MAX_BURST_LEN)) len_c = CW'(MAX_BURST_LEN);
        if (len_c > CW'(beats_to_4k))   len_c = CW'(beats_to_4k);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ax_hs && !comp_ok)      cnt_d = cnt_q + 1'b1;
        else if (!ax_hs && comp_ok) cnt_d = cnt_q - 1'b1;
    end

    // Clearing first lets a response arriving in the same cycle survive the clear.
    always_comb begin
        resp_d = i_clear_messages ? AXI_RESP_OKAY : o_resp;
        perr_d = !i_clear_messages && o_protocol_err;
        if (comp_ok) resp_d = axi_resp_worst(resp_d, comp_resp);
        if (stray)   perr_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_accept && i_cmd_num_words != '0) state_d = S_ISSUE;
            S_ISSUE: if (ax_hs && last_burst) state_d = S_DRAIN;
            S_DRAIN: if (cnt_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            remaining_q    <= '0;
            dir_q          <= 1'b0;
            id_q           <= '0;
            ax_valid_q     <= 1'b0;
            len_q          <= '0;
            o_ax_addr      <= '0;
            o_ax_len       <= '0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            o_resp         <= AXI_RESP_OKAY;
            o_protocol_err <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            o_resp         <= resp_d;
            o_protocol_err <= perr_d;
            done_q         <= (cmd_accept && i_cmd_num_words == '0) ||
                              (state_q == S_DRAIN && cnt_d == '0);
            if (cmd_accept) begin
                addr_q      <= i_cmd_addr & ~AXI_ADDR_WIDTH'((1 << SIZE) - 1);
                remaining_q <= i_cmd_num_words;
                dir_q       <= i_cmd_direction;
                id_q        <= i_cmd_id;
            end
            if (issue_ok) begin
                ax_valid_q <= 1'b1;
                o_ax_addr  <= addr_q;
                o_ax_len   <= 8'(len_c - 1'b1);
                len_q      <= len_c[8:0];
            end
            if (ax_hs) begin
                ax_valid_q  <= 1'b0;
                addr_q      <= addr_q + (AXI_ADDR_WIDTH'(len_q) << SIZE);
                remaining_q <= remaining_q - NW'(len_q);
            end
        end
    end

    sync_fifo_len #(
        .WIDTH (9),
        .DEPTH (MAX_OUTSTANDING)
    ) u_wlen_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (ax_hs && !dir_q),
        .s_tdata  (len_q),
        .m_tvalid (o_wburst_valid),
        .m_tdata  (o_wburst_len),
        .m_tready (i_wburst_ready),
        .full     (q_full)
    );

endmodule

// File: tb/tb_axi4_master_burst_splitter.sv
// tb/tb_axi4_master_burst_splitter.sv - directed self-checking bench for the burst splitter
module tb_axi4_master_burst_splitter;

    localparam int MO = 2;

    logic        clk, rst_n;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_direction;
    logic [31:0] i_cmd_addr;
    logic [12:0] i_cmd_num_words;
    logic [0:0]  i_cmd_id;
    logic [31:0] o_ax_addr;
    logic [7:0]  o_ax_len;
    logic [0:0]  o_ax_id;
    logic [2:0]  o_ax_size;
    logic [1:0]  o_ax_burst;
    logic        o_awvalid, i_awready, o_arvalid, i_arready;
    logic        i_bvalid, o_bready;
    logic [1:0]  i_bresp;
    logic        i_rlast_hs;
    logic [1:0]  i_rresp_last;
    logic [8:0]  o_wburst_len;
    logic        o_wburst_valid, i_wburst_ready;
    logic        o_busy, o_done, o_protocol_err, i_clear_messages;
    logic [1:0]  o_resp;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] aw_addr_log [32];
    logic [7:0]  aw_len_log  [32];
    logic [31:0] ar_addr_log [32];
    logic [7:0]  ar_len_log  [32];
    logic [8:0]  wq_log      [32];
    int          aw_cnt = 0;
    int          ar_cnt = 0;
    int          wq_cnt = 0;

    axi4_master_burst_splitter #(
        .AXI_ADDR_WIDTH               (32),
        .AXI_DATA_WIDTH               (32),
        .AXI_ID_WIDTH                 (1),
        .MAX_BURST_LEN                (16),
        .MAX_OUTSTANDING              (MO),
        .MAX_TOTAL_TRANSACTION_LENGTH (4096)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_cmd_valid      (i_cmd_valid),
        .o_cmd_ready      (o_cmd_ready),
        .i_cmd_direction  (i_cmd_direction),
        .i_cmd_addr       (i_cmd_addr),
        .i_cmd_num_words  (i_cmd_num_words),
        .i_cmd_id         (i_cmd_id),
        .o_ax_addr        (o_ax_addr),
        .o_ax_len         (o_ax_len),
        .o_ax_id          (o_ax_id),
        .o_ax_size        (o_ax_size),
        .o_ax_burst       (o_ax_burst),
        .o_awvalid        (o_awvalid),
        .i_awready        (i_awready),
        .o_arvalid        (o_arvalid),
        .i_arready        (i_arready),
        .i_bvalid         (i_bvalid),
        .i_bresp          (i_bresp),
        .o_bready         (o_bready),
        .i_rlast_hs       (i_rlast_hs),
        .i_rresp_last     (i_rresp_last),
        .o_wburst_len     (o_wburst_len),
        .o_wburst_valid   (o_wburst_valid),
        .i_wburst_ready   (i_wburst_ready),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_resp           (o_resp),
        .o_protocol_err   (o_protocol_err),
        .i_clear_messages (i_clear_messages)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (o_awvalid && i_awready && aw_cnt < 32) begin
                aw_addr_log[aw_cnt] <= o_ax_addr;
                aw_len_log[aw_cnt]  <= o_ax_len;
                aw_cnt              <= aw_cnt + 1;
            end
            if (o_arvalid && i_arready && ar_cnt < 32) begin
                ar_addr_log[ar_cnt] <= o_ax_addr;
                ar_len_log[ar_cnt]  <= o_ax_len;
                ar_cnt              <= ar_cnt + 1;
            end
            if (o_wburst_valid && i_wburst_ready && wq_cnt < 32) begin
                wq_log[wq_cnt] <= o_wburst_len;
                wq_cnt         <= wq_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic dir, input logic [31:0] addr, input logic [12:0] nw, input logic id);
        int k = 0;
        while (!o_cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", o_cmd_ready, 1);
        i_cmd_valid     = 1'b1;
        i_cmd_direction = dir;
        i_cmd_addr      = addr;
        i_cmd_num_words = nw;
        i_cmd_id        = id;
        @(negedge clk);
        i_cmd_valid     = 1'b0;
    endtask

    task automatic wait_aw(input int n, input int budget);
        int k = 0;
        while (aw_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_aw", aw_cnt >= n, 1);
    endtask

    task automatic wait_ar(input int n, input int budget);
        int k = 0;
        while (ar_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_ar", ar_cnt >= n, 1);
    endtask

    task automatic wait_awvalid(input int budget);
        int k = 0;
        while (!o_awvalid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_awvalid", o_awvalid, 1);
    endtask

    task automatic send_b(input logic [1:0] r);
        @(negedge clk);
        i_bvalid = 1'b1;
        i_bresp  = r;
        @(negedge clk);
        i_bvalid = 1'b0;
        i_bresp  = 2'b00;
    endtask

    initial begin
        int base_aw, base_ar, base_wq, k;
        logic seen;

        rst_n            = 1'b0;
        i_cmd_valid      = 1'b0;
        i_cmd_direction  = 1'b0;
        i_cmd_addr       = '0;
        i_cmd_num_words  = '0;
        i_cmd_id         = '0;
        i_awready        = 1'b1;
        i_arready        = 1'b1;
        i_bvalid         = 1'b0;
        i_bresp          = 2'b00;
        i_rlast_hs       = 1'b0;
        i_rresp_last     = 2'b00;
        i_wburst_ready   = 1'b1;
        i_clear_messages = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_valids", {o_awvalid, o_arvalid, o_bready, o_wburst_valid}, 4'b0000);
        check("rst_status", {o_busy, o_done, o_protocol_err, o_resp}, 5'b00000);
        check("ax_size_burst", {o_ax_size, o_ax_burst}, {3'd2, 2'b01});
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", o_cmd_ready, 1);

        // zero-length command
        base_aw = aw_cnt;
        send_cmd(1'b0, 32'h0000_0500, 13'd0, 1'b0);
        check("zero_done", o_done, 1);
        check("zero_busy", o_busy, 0);
        @(negedge clk);
        check("zero_done_pulse", {o_done, o_busy, o_awvalid, o_arvalid}, 4'b0000);
        check("zero_no_aw", aw_cnt, base_aw);

        // 40-word write from 0x1000 with bresp OKAY, SLVERR, EXOKAY
        base_aw = aw_cnt;
        base_wq = wq_cnt;
        send_cmd(1'b0, 32'h0000_1000, 13'd40, 1'b1);
        check("w40_busy", o_busy, 1);
        wait_aw(base_aw + 2, 50);
        check("w40_limit", o_awvalid, 0);
        check("w40_id", o_ax_id, 1);
        send_b(2'b00);
        wait_aw(base_aw + 3, 50);
        send_b(2'b10);
        send_b(2'b01);
        check("w40_done", {o_done, o_busy, o_cmd_ready}, 3'b101);
        check("w40_resp", o_resp, 2'b10);
        @(negedge clk);
        check("w40_done_pulse", o_done, 0);
        check("w40_resp_held", o_resp, 2'b10);
        check("w40_aw0", {aw_addr_log[base_aw],     aw_len_log[base_aw]},     {32'h1000, 8'd15});
        check("w40_aw1", {aw_addr_log[base_aw + 1], aw_len_log[base_aw + 1]}, {32'h1040, 8'd15});
        check("w40_aw2", {aw_addr_log[base_aw + 2], aw_len_log[base_aw + 2]}, {32'h1080, 8'd7});
        check("w40_wq_cnt", wq_cnt, base_wq + 3);
        check("w40_wq", {wq_log[base_wq], wq_log[base_wq + 1], wq_log[base_wq + 2]}, {9'd16, 9'd16, 9'd8});

        // clear in the same cycle as a DECERR: DECERR wins
        base_aw = aw_cnt;
        send_cmd(1'b0, 32'h0000_3000, 13'd8, 1'b0);
        wait_aw(base_aw + 1, 50);
        check("w8_aw", {aw_addr_log[base_aw], aw_len_log[base_aw]}, {32'h3000, 8'd7});
        @(negedge clk);
        i_bvalid = 1'b1;
        i_bresp = 2'b11;
        i_clear_messages = 1'b1;
        @(negedge clk);
        i_bvalid = 1'b0;
        i_bresp = 2'b00;
        i_clear_messages = 1'b0;
        check("clear_vs_decerr", o_resp, 2'b11);
        check("w8_done", o_done, 1);
        @(negedge clk);
        i_clear_messages = 1'b1;
        @(negedge clk);
        i_clear_messages = 1'b0;
        check("clear_resp", o_resp, 2'b00);

        // 10-word read across the 4 KiB boundary
        base_ar = ar_cnt;
        base_wq = wq_cnt;
        send_cmd(1'b1, 32'h0000_0FF0, 13'd10, 1'b0);
        wait_ar(base_ar + 2, 50);
        check("r10_ar0", {ar_addr_log[base_ar],     ar_len_log[base_ar]},     {32'h0FF0, 8'd3});
        check("r10_ar1", {ar_addr_log[base_ar + 1], ar_len_log[base_ar + 1]}, {32'h1000, 8'd5});
        check("r10_no_bready", {o_bready, o_arvalid, o_done}, 3'b000);
        @(negedge clk);
        i_rlast_hs = 1'b1;
        @(negedge clk);
        check("r10_not_done_yet", o_done, 0);
        @(negedge clk);
        i_rlast_hs = 1'b0;
        check("r10_done", {o_done, o_busy}, 2'b10);
        check("r10_no_wq", wq_cnt, base_wq);

        // outstanding limit and payload stability under awready backpressure
        base_aw = aw_cnt;
        i_awready = 1'b0;
        send_cmd(1'b0, 32'h0000_2000, 13'd64, 1'b0);
        wait_awvalid(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stable", {o_awvalid, o_ax_addr, o_ax_len}, {1'b1, 32'h2000, 8'd15});
        end
        i_awready = 1'b1;
        wait_aw(base_aw + 2, 50);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_awvalid) seen = 1'b1;
        end
        check("limit_holds_aw", seen, 0);
        send_b(2'b00);
        check("aw_after_first_b", o_awvalid, 1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
            i_bvalid = o_bready && !seen;
            k++;
        end
        i_bvalid = 1'b0;
        check("w64_done", seen, 1);
        check("w64_aw_cnt", aw_cnt, base_aw + 4);
        check("w64_aw2", {aw_addr_log[base_aw + 2], aw_len_log[base_aw + 2]}, {32'h2080, 8'd15});
        check("w64_aw3", {aw_addr_log[base_aw + 3], aw_len_log[base_aw + 3]}, {32'h20C0, 8'd15});
        check("w64_status", {o_resp, o_protocol_err}, 3'b000);

        // stray B while idle
        send_b(2'b10);
        check("stray_perr", o_protocol_err, 1);
        check("stray_resp", o_resp, 2'b00);

        // asynchronous reset in the middle of an issue
        i_awready = 1'b0;
        send_cmd(1'b0, 32'h0000_5000, 13'd64, 1'b1);
        wait_awvalid(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valids", {o_awvalid, o_arvalid, o_bready, o_wburst_valid}, 4'b0000);
        check("async_rst_status", {o_busy, o_done, o_cmd_ready, o_protocol_err, o_resp}, 6'b000000);
        @(negedge clk);
        i_awready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_ready", {o_cmd_ready, o_awvalid}, 2'b10);

        // 8-word read from an unaligned address after reset
        base_ar = ar_cnt;
        send_cmd(1'b1, 32'h0000_4003, 13'd8, 1'b0);
        wait_ar(base_ar + 1, 50);
        check("r8_ar", {ar_addr_log[base_ar], ar_len_log[base_ar]}, {32'h4000, 8'd7});
        @(negedge clk);
        check("r8_single", {o_arvalid, o_busy}, 2'b01);
        i_rlast_hs = 1'b1;
        @(negedge clk);
        i_rlast_hs = 1'b0;
        check("r8_done", {o_done, o_busy}, 2'b10);
        check("r8_ar_cnt", ar_cnt, base_ar + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
